flagram_scanner: RTL and testbench

- Bus master that drives the read side of the 4-bit flag-RAM block (full_flagram) and sweeps every address.
- For each word it reads the data, then reads the 16-bit flag vector latched for that word, and tests the flags against a programmable mask.
- Reports whether any word matched, the first matching address and data, and the total match count.
- Sits between a control FSM or testbench and the flag RAM, on the master side of that interface.

---
 rtl/flagram_scanner_if.sv | 28 ++
 rtl/flagram_scanner.sv | 181 ++++++++++++++++++
 tb/tb_flagram_scanner.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/flagram_scanner_if.sv
// Read-side bus between the flag scanner (master) and the flag RAM (slave).
// The scanner drives address and read enables; the RAM returns data or flags on one shared bus.
interface flagram_scanner_if #(
    parameter int p_address_width = 4,
    parameter int p_flags_width   = 16
);
    logic [p_address_width-1:0] o_w_address;
    logic                       o_w_we;
    logic                       o_w_oe;
    logic                       o_w_flags_out;
    logic [p_flags_width-1:0]   i_w_bus;

    modport master (
        output o_w_address,
        output o_w_we,
        output o_w_oe,
        output o_w_flags_out,
        input  i_w_bus
    );

    modport slave (
        input  o_w_address,
        input  o_w_we,
        input  o_w_oe,
        input  o_w_flags_out,
        output i_w_bus
    );
endinterface

// File: rtl/flagram_scanner.sv
// Flag-RAM scanner: sweeps every word, reads data then latched flags, and reports the
// first match, its data and the total match count against a programmable mask.
module flagram_scanner #(
    parameter int p_address_width = 4,
    parameter int p_data_width    = 4,
    parameter int p_flags_width   = 16
) (
    input  logic                       i_w_clk,
    input  logic                       i_w_reset,
    input  logic                       i_w_start,
    input  logic [p_flags_width-1:0]   i_w_mask,
    input  logic                       i_w_mode_any,
    flagram_scanner_if.master          ram,
    output logic                       o_w_busy,
    output logic                       o_w_done,
    output logic                       o_w_found,
    output logic [p_address_width-1:0] o_w_first_addr,
    output logic [p_data_width-1:0]    o_w_first_data,
    output logic [p_address_width:0]   o_w_count
);

    localparam int c_count_width = p_address_width + 1;
    localparam logic [p_address_width-1:0] c_addr_last = {p_address_width{1'b1}};
    localparam logic [p_address_width-1:0] c_addr_step = {{(p_address_width-1){1'b0}}, 1'b1};
    localparam logic [c_count_width-1:0]   c_count_step = {{p_address_width{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_FL   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                     state_r;
    logic [p_address_width-1:0] addr_r;
    logic [p_flags_width-1:0]   mask_r;
    logic                       mode_any_r;
    logic [p_data_width-1:0]    data_r;
    logic                       oe_r;
    logic                       flags_out_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       found_r;
    logic [p_address_width-1:0] first_addr_r;
    logic [p_data_width-1:0]    first_data_r;
    logic [c_count_width-1:0]   count_r;
    logic                       hit_s;

    // Any mode needs one masked flag set; all mode needs every masked flag set (empty mask always matches).
    function automatic logic flag_hit(input logic [p_flags_width-1:0] flags,
                                      input logic [p_flags_width-1:0] mask,
                                      input logic                     mode_any);
        logic [p_flags_width-1:0] masked;
        masked = flags & mask;
        if (mode_any) begin
            flag_hit = |masked;
        end else begin
            flag_hit = (masked == mask);
        end
    endfunction

    assign hit_s = flag_hit(ram.i_w_bus, mask_r, mode_any_r);

    // Scan sequencer: every bus enable and result is a register, so reset drops them at once.
    always_ff @(posedge i_w_clk or negedge i_w_reset) begin
        if (!i_w_reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= {p_address_width{1'b0}};
            mask_r       <= {p_flags_width{1'b0}};
            mode_any_r   <= 1'b0;
            data_r       <= {p_data_width{1'b0}};
            oe_r         <= 1'b0;
            flags_out_r  <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            found_r      <= 1'b0;
            first_addr_r <= {p_address_width{1'b0}};
            first_data_r <= {p_data_width{1'b0}};
            count_r      <= {c_count_width{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (i_w_start) begin
                        mask_r       <= i_w_mask;
                        mode_any_r   <= i_w_mode_any;
                        found_r      <= 1'b0;
                        first_addr_r <= {p_address_width{1'b0}};
                        first_data_r <= {p_data_width{1'b0}};
                        count_r      <= {c_count_width{1'b0}};
                        addr_r       <= {p_address_width{1'b0}};
                        oe_r         <= 1'b1;
                        flags_out_r  <= 1'b0;
                        busy_r       <= 1'b1;
                        state_r      <= ST_RD;
                    end else begin
                        oe_r        <= 1'b0;
                        flags_out_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                ST_RD: begin
                    // The RAM latches this word's flags on the same edge.
                    data_r      <= ram.i_w_bus[p_data_width-1:0];
                    oe_r        <= 1'b0;
                    flags_out_r <= 1'b1;
                    state_r     <= ST_FL;
                end
                ST_FL: begin
                    if (hit_s) begin
                        count_r <= count_r + c_count_step;
                        if (!found_r) begin
                            found_r      <= 1'b1;
                            first_addr_r <= addr_r;
                            first_data_r <= data_r;
                        end
                    end
                    if (addr_r == c_addr_last) begin
                        flags_out_r <= 1'b0;
                        busy_r      <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else begin
                        addr_r      <= addr_r + c_addr_step;
                        oe_r        <= 1'b1;
                        flags_out_r <= 1'b0;
                        state_r     <= ST_RD;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    oe_r        <= 1'b0;
                    flags_out_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign ram.o_w_address   = addr_r;
    assign ram.o_w_we        = 1'b0;
    assign ram.o_w_oe        = oe_r;
    assign ram.o_w_flags_out = flags_out_r;
    assign o_w_busy          = busy_r;
    assign o_w_done          = done_r;
    assign o_w_found         = found_r;
    assign o_w_first_addr    = first_addr_r;
    assign o_w_first_data    = first_data_r;
    assign o_w_count         = count_r;

    flagram_scanner_checker u_checker (
        .clk       (i_w_clk),
        .rst_n     (i_w_reset),
        .we        (ram.o_w_we),
        .oe        (oe_r),
        .flags_out (flags_out_r),
        .busy      (busy_r),
        .done      (done_r)
    );

endmodule

// Protocol properties of the scanner's bus side.
module flagram_scanner_checker (
    input logic clk,
    input logic rst_n,
    input logic we,
    input logic oe,
    input logic flags_out,
    input logic busy,
    input logic done
);
    a_no_write: assert property (@(posedge clk) disable iff (!rst_n) !we);
    a_one_enable: assert property (@(posedge clk) disable iff (!rst_n) !(oe && flags_out));
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) !(done && busy));
endmodule

// File: tb/tb_flagram_scanner.sv
// Randomized bench for flagram_scanner with a behavioural flag RAM and a scan-result model.
module tb_flagram_scanner;
    localparam int AW = 4;
    localparam int DW = 4;
    localparam int FW = 16;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          mode_any = 1'b0;
    logic [FW-1:0] mask = '0;
    logic          busy, done, found;
    logic [AW-1:0] first_addr;
    logic [DW-1:0] first_data;
    logic [AW:0]   count;

    logic [DW-1:0] mem [NW];
    logic [FW-1:0] flag_q = '0;
    int compared_cnt = 0;
    int mismatch_cnt = 0;

    flagram_scanner_if #(.p_address_width(AW), .p_flags_width(FW)) ram_if ();

    flagram_scanner #(.p_address_width(AW), .p_data_width(DW), .p_flags_width(FW)) dut (
        .i_w_clk        (clk),
        .i_w_reset      (rst_n),
        .i_w_start      (start),
        .i_w_mask       (mask),
        .i_w_mode_any   (mode_any),
        .ram            (ram_if.master),
        .o_w_busy       (busy),
        .o_w_done       (done),
        .o_w_found      (found),
        .o_w_first_addr (first_addr),
        .o_w_first_data (first_data),
        .o_w_count      (count)
    );

    always #5 clk = ~clk;

    // Flag vector the RAM derives from a data word (bit 9 = SMAX, bit 11 = MAX).
    function automatic logic [FW-1:0] flags_of(input logic [DW-1:0] d);
        logic [FW-1:0] f;
        f = '0;
        f[0]  = (d == 4'd0);
        f[1]  = (d == 4'd1);
        f[2]  = d[0];
        f[3]  = ~d[0];
        f[4]  = d[3];
        f[5]  = ^d;
        f[6]  = ~d[3];
        f[7]  = (d > 4'd9);
        f[8]  = (d == 4'd8);
        f[9]  = (d == 4'd7);
        f[10] = ($countones(d) == 2);
        f[11] = (d == 4'd15);
        f[15:12] = d;
        return f;
    endfunction

    always_comb begin
        ram_if.i_w_bus = '0;
        if (ram_if.o_w_oe) begin
            ram_if.i_w_bus = {12'h000, mem[ram_if.o_w_address]};
        end else if (ram_if.o_w_flags_out) begin
            ram_if.i_w_bus = flag_q;
        end
    end

    always @(posedge clk) begin
        if (ram_if.o_w_oe) flag_q <= flags_of(mem[ram_if.o_w_address]);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared_cnt++;
        if (obs !== exp) begin
            mismatch_cnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic expect_results(input logic [FW-1:0] m, input logic mode);
        int  e_cnt = 0;
        bit  e_found = 1'b0;
        int  e_fa = 0;
        int  e_fd = 0;
        logic [FW-1:0] fm;
        bit  hit;
        for (int a = 0; a < NW; a++) begin
            fm  = flags_of(mem[a]) & m;
            hit = mode ? (fm != '0) : (fm == m);
            if (hit) begin
                if (!e_found) begin
                    e_found = 1'b1;
                    e_fa = a;
                    e_fd = int'(mem[a]);
                end
                e_cnt++;
            end
        end
        check_eq("found", 32'(found), 32'(e_found));
        check_eq("first_addr", 32'(first_addr), e_fa);
        check_eq("first_data", 32'(first_data), e_fd);
        check_eq("count", 32'(count), e_cnt);
    endtask

    task automatic run_scan(input logic [FW-1:0] m, input logic mode, input bit poke_start);
        @(negedge clk);
        mask = m;
        mode_any = mode;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mask = FW'($urandom);
        mode_any = 1'($urandom);
        for (int k = 0; k < 2 * NW; k++) begin
            @(negedge clk);
            start = (poke_start && (k == 9)) ? 1'b1 : 1'b0;
            check_eq("busy", 32'(busy), 32'h1);
            check_eq("done_early", 32'(done), 32'h0);
            check_eq("address", 32'(ram_if.o_w_address), k / 2);
            check_eq("oe", 32'(ram_if.o_w_oe), ((k % 2) == 0) ? 32'h1 : 32'h0);
            check_eq("flags_out", 32'(ram_if.o_w_flags_out), ((k % 2) == 1) ? 32'h1 : 32'h0);
            check_eq("we", 32'(ram_if.o_w_we), 32'h0);
        end
        @(negedge clk);
        start = 1'b0;
        check_eq("done", 32'(done), 32'h1);
        check_eq("busy_at_done", 32'(busy), 32'h0);
        check_eq("oe_at_done", 32'(ram_if.o_w_oe), 32'h0);
        check_eq("flags_out_at_done", 32'(ram_if.o_w_flags_out), 32'h0);
        @(negedge clk);
        check_eq("done_pulse_end", 32'(done), 32'h0);
        check_eq("busy_after", 32'(busy), 32'h0);
        expect_results(m, mode);
    endtask

    initial begin
        for (int i = 0; i < NW; i++) mem[i] = 4'd0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_address", 32'(ram_if.o_w_address), 32'h0);
        check_eq("rst_oe", 32'(ram_if.o_w_oe), 32'h0);
        check_eq("rst_flags_out", 32'(ram_if.o_w_flags_out), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_done", 32'(done), 32'h0);
        check_eq("rst_found", 32'(found), 32'h0);
        check_eq("rst_first_addr", 32'(first_addr), 32'h0);
        check_eq("rst_first_data", 32'(first_data), 32'h0);
        check_eq("rst_count", 32'(count), 32'h0);
        rst_n = 1'b1;

        // SMAX search in all mode, then SMAX|MAX in any mode with a start poked mid-scan.
        mem[5] = 4'd7;
        mem[9] = 4'd15;
        run_scan(16'h0200, 1'b0, 1'b0);
        check_eq("smax_found", 32'(found), 32'h1);
        check_eq("smax_first_addr", 32'(first_addr), 32'h5);
        check_eq("smax_first_data", 32'(first_data), 32'h7);
        check_eq("smax_count", 32'(count), 32'h1);
        run_scan(16'h0A00, 1'b1, 1'b1);
        check_eq("any_found", 32'(found), 32'h1);
        check_eq("any_first_addr", 32'(first_addr), 32'h5);
        check_eq("any_count", 32'(count), 32'h2);

        run_scan(16'h0000, 1'b0, 1'b0);
        check_eq("mask0_all_count", 32'(count), 32'h10);
        check_eq("mask0_all_first_addr", 32'(first_addr), 32'h0);
        check_eq("mask0_all_first_data", 32'(first_data), 32'h0);
        run_scan(16'h0000, 1'b1, 1'b0);
        check_eq("mask0_any_found", 32'(found), 32'h0);
        check_eq("mask0_any_count", 32'(count), 32'h0);

        for (int i = 0; i < NW; i++) mem[i] = 4'd0;
        run_scan(16'h0800, 1'($urandom), 1'b0);
        check_eq("nomatch_found", 32'(found), 32'h0);
        check_eq("nomatch_count", 32'(count), 32'h0);
        check_eq("nomatch_first_addr", 32'(first_addr), 32'h0);

        // Reset during FL at address 7.
        for (int i = 0; i < NW; i++) mem[i] = 4'($urandom);
        @(negedge clk);
        mask = 16'hFFFF;
        mode_any = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (16) @(negedge clk);
        check_eq("mid_flags_out", 32'(ram_if.o_w_flags_out), 32'h1);
        check_eq("mid_address", 32'(ram_if.o_w_address), 32'h7);
        #1 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_oe", 32'(ram_if.o_w_oe), 32'h0);
        check_eq("mid_rst_flags_out", 32'(ram_if.o_w_flags_out), 32'h0);
        check_eq("mid_rst_busy", 32'(busy), 32'h0);
        check_eq("mid_rst_count", 32'(count), 32'h0);
        check_eq("mid_rst_found", 32'(found), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("mid_rst_no_done", 32'(done), 32'h0);
        end
        rst_n = 1'b1;
        run_scan(16'h0200 | FW'($urandom_range(0, 3)), 1'b1, 1'b0);

        for (int r = 0; r < 8; r++) begin
            logic          rmode;
            logic [FW-1:0] rmask;
            for (int i = 0; i < NW; i++) mem[i] = 4'($urandom);
            rmode = 1'($urandom);
            if (rmode) rmask = FW'($urandom) & FW'($urandom);
            else       rmask = (FW'(1) << $urandom_range(0, FW - 1)) | (FW'(1) << $urandom_range(0, FW - 1));
            run_scan(rmask, rmode, (r % 2) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
        $finish;
    end
endmodule
